// File: rtl/ic_pkg.sv
// Shared types and widths for the input-capture period sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ic_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    WAIT1 = 3'd2,
    ACK1  = 3'd3,
    MEAS  = 3'd4,
    ACK   = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/ic_watchdog.sv
// Inactivity watchdog: reloadable down-counter that flags expiry after TIMEOUT_CYC enabled cycles.
// Latency: expired is combinational on the TIMEOUT_CYC-th enabled cycle after a reload.
// Backpressure: none; the counter holds its value while en is low.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   reload    restart the count window (takes priority over en)
//   en        count this cycle
//   expired   high during the last permitted enabled cycle
module ic_watchdog #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] remain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= '0;
    end else if (reload) begin
      remain <= W'(TIMEOUT_CYC);
    end else if (en && remain != '0) begin
      remain <= remain - 1'b1;
    end
  end

  // remain==1 means this enabled cycle is the TIMEOUT_CYC-th one since reload.
  assign expired = en && (remain == W'(1));

endmodule

// File: rtl/ic_period_ctrl.sv
// Sequencer for input_capture: arms the counter, acks each capture flag, averages 2^LOG2_AVG periods.
// Latency: o_valid one cycle after the ACK exit that follows the final capture of a batch.
// Backpressure: o_clr is held until the capture flag is seen low; i_start is ignored while busy.
//
// Ports:
//   i_sysclk, i_sysrst   clock, asynchronous active-high reset
//   i_start, i_stop      start pulse / abort (abort has priority)
//   i_cont               sampled with i_start: keep measuring after each result
//   i_ic_flg, i_cnt      capture flag and captured count from input_capture
//   o_cnt_en, o_clr      counter enable and flag clear to input_capture
//   o_period, o_valid    averaged period and its one-cycle update strobe
//   o_busy, o_timeout    not-idle indicator, sticky watchdog abort indicator
module ic_period_ctrl
  import ic_pkg::*;
#(
  parameter int LOG2_AVG    = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cont,
  input  logic             i_ic_flg,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_cnt_en,
  output logic             o_clr,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_timeout
);

  localparam int ACC_W = CNT_W + LOG2_AVG;
  localparam int SMP_W = LOG2_AVG + 1;
  localparam logic [SMP_W-1:0] N_AVG = SMP_W'(1 << LOG2_AVG);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] prev;
  logic [ACC_W-1:0] acc;
  logic [SMP_W-1:0] smp;
  logic             cont;

  logic             waiting;
  logic             start_ok;
  logic             capture;
  logic             wd_en;
  logic             wd_exp;
  logic             timeout;
  logic [CNT_W-1:0] diff;

  assign waiting  = (state == WAIT1) || (state == MEAS);
  assign start_ok = (state == IDLE) && i_start && !i_stop;
  // A capture in the same cycle as watchdog expiry wins: wd_en is low then.
  assign capture  = waiting && i_ic_flg && !i_stop;
  assign wd_en    = waiting && !i_ic_flg;
  assign timeout  = wd_exp && !i_stop;
  // Modulo-2^16 difference absorbs counter wrap between captures.
  assign diff     = i_cnt - prev;

  ic_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (i_sysclk),
    .rst    (i_sysrst),
    .reload (start_ok || capture),
    .en     (wd_en),
    .expired(wd_exp)
  );

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = ARM;
      ARM:   state_nxt = WAIT1;
      WAIT1: begin
        if (i_ic_flg)    state_nxt = ACK1;
        else if (wd_exp) state_nxt = IDLE;
      end
      ACK1:  if (!i_ic_flg) state_nxt = MEAS;
      MEAS: begin
        if (i_ic_flg)    state_nxt = ACK;
        else if (wd_exp) state_nxt = IDLE;
      end
      ACK:   if (!i_ic_flg) state_nxt = (smp == N_AVG) ? DONE : MEAS;
      DONE:  state_nxt = cont ? MEAS : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_stop) state_nxt = IDLE;
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      o_cnt_en  <= 1'b0;
      o_clr     <= 1'b0;
      o_period  <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      prev      <= '0;
      acc       <= '0;
      smp       <= '0;
      cont      <= 1'b0;
    end else begin
      o_valid  <= 1'b0;
      o_busy   <= (state_nxt != IDLE);
      o_cnt_en <= (state_nxt != IDLE);
      o_clr    <= (state_nxt inside {ARM, ACK1, ACK});

      if (start_ok) begin
        cont      <= i_cont;
        o_timeout <= 1'b0;
        acc       <= '0;
        smp       <= '0;
      end

      // The WAIT1 capture only sets the reference; MEAS captures add a period.
      if (capture) begin
        prev <= i_cnt;
        if (state == MEAS) begin
          acc <= acc + ACC_W'(diff);
          smp <= smp + 1'b1;
        end
      end

      // prev is kept so continuous mode measures from the last capture.
      if (state == DONE && !i_stop) begin
        o_period <= CNT_W'(acc >> LOG2_AVG);
        o_valid  <= 1'b1;
        acc      <= '0;
        smp      <= '0;
      end

      if (timeout) o_timeout <= 1'b1;

      if (i_stop || timeout) begin
        acc <= '0;
        smp <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ic_period_ctrl.sv
// Scoreboard bench for ic_period_ctrl: directed spec scenarios plus randomized capture batches.
// Latency: n/a.
// Backpressure: the flag model holds each capture until o_clr has been high for a chosen time.
module tb_ic_period_ctrl;

  localparam int L    = 2;
  localparam int NAVG = 1 << L;
  localparam int TO   = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cont;
  logic        flg;
  logic [15:0] cnt;
  logic        o_cnt_en;
  logic        o_clr;
  logic [15:0] o_period;
  logic        o_valid;
  logic        o_busy;
  logic        o_timeout;

  always #5 clk = ~clk;

  ic_period_ctrl #(
    .LOG2_AVG   (L),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_sysclk (clk),
    .i_sysrst (rst),
    .i_start  (start),
    .i_stop   (stop),
    .i_cont   (cont),
    .i_ic_flg (flg),
    .i_cnt    (cnt),
    .o_cnt_en (o_cnt_en),
    .o_clr    (o_clr),
    .o_period (o_period),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  int          busy_low = 0;
  bit          busy_watch = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] last_period = 16'd0;
  logic [15:0] c  [NAVG+1];
  logic [15:0] c2 [NAVG+1];
  logic [15:0] c9 [2*NAVG+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: mean of the modulo-65536 gaps between consecutive captures, truncated.
  function automatic logic [15:0] ref_period(input logic [15:0] v[NAVG+1]);
    longint sum = 0;
    for (int i = 1; i <= NAVG; i++)
      sum += (int'(v[i]) - int'(v[i-1]) + 65536) % 65536;
    return 16'(sum / NAVG);
  endfunction

  task automatic gen_caps(input logic [15:0] first, output logic [15:0] v[NAVG+1]);
    int r;
    logic [15:0] d;
    v[0] = first;
    for (int i = 1; i <= NAVG; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)     d = 16'd0;
      else if (r < 4) d = 16'($urandom_range(40000, 65535));
      else            d = 16'($urandom_range(1, 3000));
      v[i] = v[i-1] + d;
    end
  endtask

  // Scoreboard monitor: every o_valid must match the oldest expected period.
  always @(negedge clk) begin
    if (busy_watch && !o_busy) busy_low++;
    if (o_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
      end else begin
        chk("period", {16'd0, o_period}, {16'd0, exp_q[0]});
        last_period = exp_q.pop_front();
      end
    end
  end

  task automatic do_start(input logic c_mode);
    start = 1'b1;
    cont  = c_mode;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    chk("timeout_cleared", {31'd0, o_timeout}, 32'd0);
    chk("arm_clr", {31'd0, o_clr}, 32'd1);
  endtask

  // Flag model: raise the flag after gap cycles, drop it once o_clr has been high hold cycles.
  task automatic do_capture(input logic [15:0] v, input int gap, input int hold);
    int n;
    repeat (gap) @(negedge clk);
    cnt = v;
    flg = 1'b1;
    n = 0;
    while (!o_clr && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!o_clr) begin
      chk("clr_rise", {31'd0, o_clr}, 32'd1);
      flg = 1'b0;
      return;
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("clr_hold", {31'd0, o_clr}, 32'd1);
    end
    flg = 1'b0;
    @(negedge clk);
    chk("clr_release", {31'd0, o_clr}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

  initial begin
    int v0;
    logic [15:0] old;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; flg = 1'b0; cnt = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_cnt_en", {31'd0, o_cnt_en}, 32'd0);
    chk("rst_clr", {31'd0, o_clr}, 32'd0);
    chk("rst_period", {16'd0, o_period}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic measurement
    c = '{16'd100, 16'd106, 16'd112, 16'd118, 16'd124};
    exp_q.push_back(ref_period(c));
    v0 = n_valid;
    do_start(1'b0);
    chk("busy_cnt_en", {31'd0, o_cnt_en}, 32'd1);
    for (int i = 0; i <= NAVG; i++) do_capture(c[i], 2, 1);
    wait_idle();
    chk("basic_period", {16'd0, o_period}, 32'd6);
    chk("basic_nvalid", n_valid - v0, 1);
    chk("basic_cnt_en_off", {31'd0, o_cnt_en}, 32'd0);

    // Wrap-around
    c = '{16'hFFF0, 16'hFFFA, 16'h0004, 16'h000E, 16'h0018};
    exp_q.push_back(ref_period(c));
    do_start(1'b0);
    for (int i = 0; i <= NAVG; i++) do_capture(c[i], 3, 1);
    wait_idle();
    chk("wrap_period", {16'd0, o_period}, 32'd10);

    // Continuous mode: 9 captures, two results, never idle in between
    for (int i = 0; i <= 2*NAVG; i++) c9[i] = 16'(200 + 6*i);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd6);
    v0 = n_valid;
    busy_low = 0;
    do_start(1'b1);
    busy_watch = 1'b1;
    for (int i = 0; i <= 2*NAVG; i++) do_capture(c9[i], 2, 1);
    repeat (3) @(negedge clk);
    busy_watch = 1'b0;
    chk("cont_nvalid", n_valid - v0, 2);
    chk("cont_busy_low", busy_low, 0);
    chk("cont_last_period", {16'd0, o_period}, 32'd6);
    do_stop();
    chk("cont_stop_idle", {31'd0, o_busy}, 32'd0);

    // Timeout: one capture then silence
    v0 = n_valid;
    do_start(1'b0);
    do_capture(16'd300, 2, 1);
    repeat (TO - 1) @(negedge clk);
    chk("to_not_yet", {31'd0, o_timeout}, 32'd0);
    chk("to_busy_before", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    chk("to_set", {31'd0, o_timeout}, 32'd1);
    chk("to_cnt_en", {31'd0, o_cnt_en}, 32'd0);
    chk("to_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("to_sticky", {31'd0, o_timeout}, 32'd1);
    chk("to_nvalid", n_valid - v0, 0);
    do_start(1'b0);
    do_stop();

    // Simultaneous start and stop in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", {31'd0, o_busy}, 32'd0);
    chk("startstop_clr", {31'd0, o_clr}, 32'd0);

    // Stop after 2 of 4 periods
    old = last_period;
    v0 = n_valid;
    do_start(1'b0);
    for (int i = 0; i < 3; i++) do_capture(16'(500 + 7*i), 2, 1);
    repeat (2) @(negedge clk);
    do_stop();
    chk("stop_busy", {31'd0, o_busy}, 32'd0);
    chk("stop_cnt_en", {31'd0, o_cnt_en}, 32'd0);
    chk("stop_clr", {31'd0, o_clr}, 32'd0);
    chk("stop_period", {16'd0, o_period}, {16'd0, old});
    repeat (3) @(negedge clk);
    chk("stop_nvalid", n_valid - v0, 0);

    // Reset asserted while o_clr is held in ACK
    do_start(1'b0);
    do_capture(16'd700, 2, 1);
    do_capture(16'd710, 2, 1);
    @(negedge clk);
    cnt = 16'd720;
    flg = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_clr", {31'd0, o_clr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_clr", {31'd0, o_clr}, 32'd0);
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_cnt_en", {31'd0, o_cnt_en}, 32'd0);
    chk("arst_period", {16'd0, o_period}, 32'd0);
    chk("arst_timeout", {31'd0, o_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    flg = 1'b0;
    last_period = 16'd0;
    @(negedge clk);

    // Handshake: flag drop delayed, o_clr held 3 cycles per capture
    c = '{16'd1000, 16'd1010, 16'd1020, 16'd1030, 16'd1040};
    exp_q.push_back(ref_period(c));
    v0 = n_valid;
    do_start(1'b0);
    for (int i = 0; i <= NAVG; i++) do_capture(c[i], 2, 3);
    wait_idle();
    chk("hs_period", {16'd0, o_period}, 32'd10);
    chk("hs_nvalid", n_valid - v0, 1);

    // Randomized single-shot batches
    for (int it = 0; it < 12; it++) begin
      gen_caps(16'($urandom), c);
      exp_q.push_back(ref_period(c));
      do_start(1'b0);
      for (int i = 0; i <= NAVG; i++)
        do_capture(c[i], $urandom_range(1, 12), $urandom_range(1, 4));
      wait_idle();
    end

    // Randomized continuous run: three results chained from the last capture
    gen_caps(16'($urandom), c);
    exp_q.push_back(ref_period(c));
    do_start(1'b1);
    for (int i = 0; i <= NAVG; i++)
      do_capture(c[i], $urandom_range(1, 12), $urandom_range(1, 4));
    for (int b = 0; b < 2; b++) begin
      gen_caps(c[NAVG], c2);
      exp_q.push_back(ref_period(c2));
      for (int i = 1; i <= NAVG; i++)
        do_capture(c2[i], $urandom_range(1, 12), $urandom_range(1, 4));
      c = c2;
    end
    repeat (3) @(negedge clk);
    do_stop();
    repeat (2) @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
